muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port input1  input  XLEN  multiplicand/dividend.
REQ-007 SHALL have port input2  input  XLEN  multiplier/divisor.
REQ-008 SHALL have port busy  output  1  operation in progress.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port hi  output  XLEN  upper product half / remainder.
REQ-011 SHALL have port lo  output  XLEN  lower product half / quotient.
REQ-012 SHALL have port div_by_zero  output  1  last division had input2 == 0; valid with done.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> FIX -> IDLE; IDLE -> RUN on start=1 at edge N, capturing op, input1 and input2.
REQ-014 SHALL perform one iteration per edge N+1..N+XLEN: shift-add multiply or restoring divide on operand magnitudes, 5-bit-style counter sized clog2(XLEN); RUN -> FIX after the XLEN-th iteration.
REQ-015 SHALL, at edge N+XLEN+1 (FIX -> IDLE), apply sign correction, write hi/lo, and assert done for exactly one cycle; total latency XLEN+1 cycles.
REQ-016 SHALL drive busy=1 from after edge N until the edge that asserts done; busy=0 while done=1.
REQ-017 SHALL ignore start and input changes while busy=1.
REQ-018 SHALL accept start in the cycle done=1 (FSM is IDLE).
REQ-019 SHALL hold hi, lo and div_by_zero stable between completions.
REQ-020 SHALL, for multiply, produce the 2*XLEN-bit product as {hi,lo}; MULT uses two's complement, MULTU unsigned.
REQ-021 SHALL, for divide, put the quotient in lo and the remainder in hi; DIV truncates toward zero, quotient sign = sign(input1) XOR sign(input2), remainder sign = sign(input1).
REQ-022 SHALL, for divisor zero (DIVU or DIV), return lo = all ones and hi = input1, assert div_by_zero, and keep the full XLEN+1 latency.
REQ-023 SHALL, for DIV with the most-negative dividend and -1, return lo = most-negative value and hi = 0.
REQ-024 SHALL clear div_by_zero on every multiply completion and on every nonzero-divisor completion.

Reset
REQ-025 SHALL, on rst_n=0 at any time, immediately force FSM=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0, and clear the counter and internal registers.
REQ-026 SHALL discard an in-flight operation on reset; no done pulse follows the deassertion of reset.

Configuration
REQ-027 SHALL, with macro MULDIV_FLUSH_EN defined, add port flush (input, 1); flush=1 in RUN or FIX returns the FSM to IDLE at the next edge with busy=0, no done, and hi/lo/div_by_zero unchanged; flush has priority over start.
REQ-028 SHALL, without MULDIV_FLUSH_EN, omit the flush port and flush logic; all other behaviour is identical.

Verification (XLEN=32)
REQ-029 SHALL cover MULT 0xFFFFFFFD * 0x00000005 -> done exactly 33 cycles after start, hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy high for 33 cycles.
REQ-030 SHALL cover MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 SHALL cover DIV 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_by_zero=0.
REQ-032 SHALL cover DIVU 0x00000064 / 0 -> lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1 with done; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 SHALL cover start pulsed with new operands at cycle 10 of a running op -> ignored, first result unchanged; back-to-back start in the done cycle -> second done 33 cycles later.
REQ-034 SHALL cover rst_n low at cycle 15 of a multiply -> all outputs 0 asynchronously, no done after release; with MULDIV_FLUSH_EN, flush at cycle 15 -> busy=0 next cycle, no done, hi/lo keep prior values.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if -- request/result bundle for muldiv_unit.
//
// Signals:
//   start        request strobe (sampled by the unit only while idle)
//   op           00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   input1       multiplicand / dividend
//   input2       multiplier / divisor
//   busy         operation in progress
//   done         one-cycle completion pulse
//   hi           upper product half / remainder
//   lo           lower product half / quotient
//   div_by_zero  last division had a zero divisor (valid with done)
//
// Modports: master = requester side, slave = muldiv_unit side.
interface muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] input1;
   logic [XLEN-1:0] input2;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic            div_by_zero;

   modport master (
      output start, op, input1, input2,
      input  busy, done, hi, lo, div_by_zero
   );

   modport slave (
      input  start, op, input1, input2,
      output busy, done, hi, lo, div_by_zero
   );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative XLEN-bit multiply / divide unit.
//
// One shift-add (multiply) or restoring-divide step per clock on operand
// magnitudes, followed by a sign-fixup cycle.  Latency start->done is XLEN+1.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   flush  (only with MULDIV_FLUSH_EN) abandon the running operation
//   bus    muldiv_unit_if.slave: start/op/input1/input2 in,
//          busy/done/hi/lo/div_by_zero out (all outputs registered)
//
// Build option: define MULDIV_FLUSH_EN to add the flush port.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic clk,
   input  logic rst_n,
`ifdef MULDIV_FLUSH_EN
   input  logic flush,
`endif
   muldiv_unit_if.slave bus
);

   localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
   localparam int PW = 2 * XLEN;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   // Two's-complement negate when n is set.
   function automatic logic [XLEN-1:0] neg_x(input logic n, input logic [XLEN-1:0] v);
      return n ? (~v + XLEN'(1)) : v;
   endfunction

   // Double-width variant for the product.
   function automatic logic [PW-1:0] neg_p(input logic n, input logic [PW-1:0] v);
      return n ? (~v + PW'(1)) : v;
   endfunction

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      op_q, op_d;
   logic            qneg_q, qneg_d;     // product / quotient negative
   logic            rneg_q, rneg_d;     // remainder negative
   logic [XLEN-1:0] acc_q, acc_d;       // product high half / partial remainder
   logic [XLEN-1:0] mq_q, mq_d;         // multiplier -> product low / dividend -> quotient
   logic [XLEN-1:0] mcand_q, mcand_d;   // multiplicand or divisor magnitude
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic            dz_q, dz_d;

   logic            flush_s;
   logic            s1_s, s2_s;
   logic [XLEN-1:0] mag1_s, mag2_s;
   logic [XLEN:0]   mul_sum_s;
   logic [XLEN:0]   rem_sh_s;
   logic [XLEN:0]   div_diff_s;
   logic [PW-1:0]   prod_s;

`ifdef MULDIV_FLUSH_EN
   assign flush_s = flush;
`else
   assign flush_s = 1'b0;
`endif

   // op[0] selects signed operation; magnitudes are taken only for signed ops.
   assign s1_s   = bus.op[0] & bus.input1[XLEN-1];
   assign s2_s   = bus.op[0] & bus.input2[XLEN-1];
   assign mag1_s = neg_x(s1_s, bus.input1);
   assign mag2_s = neg_x(s2_s, bus.input2);

   // Multiply step: add multiplicand when the multiplier LSB is set; the carry
   // bit is shifted back into acc so nothing is lost.
   assign mul_sum_s  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
   // Divide step: partial remainder stays below the divisor, so XLEN+1 bits suffice.
   assign rem_sh_s   = {acc_q, mq_q[XLEN-1]};
   assign div_diff_s = rem_sh_s - {1'b0, mcand_q};
   assign prod_s     = neg_p(qneg_q, {acc_q, mq_q});

   // Next-state, datapath step and output computation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      acc_d   = acc_q;
      mq_d    = mq_q;
      mcand_d = mcand_q;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dz_d    = dz_q;

      if (flush_s) begin
         // Abandon without a done pulse; result registers keep their values.
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_d = S_RUN;
                  cnt_d   = '0;
                  op_d    = bus.op;
                  qneg_d  = s1_s ^ s2_s;
                  rneg_d  = s1_s;
                  acc_d   = '0;
                  mq_d    = bus.op[1] ? mag1_s : mag2_s;
                  mcand_d = bus.op[1] ? mag2_s : mag1_s;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_RUN: begin
               cnt_d = cnt_q + CW'(1);
               if (op_q[1]) begin
                  if (!div_diff_s[XLEN]) begin
                     acc_d = div_diff_s[XLEN-1:0];
                     mq_d  = {mq_q[XLEN-2:0], 1'b1};
                  end else begin
                     acc_d = rem_sh_s[XLEN-1:0];
                     mq_d  = {mq_q[XLEN-2:0], 1'b0};
                  end
               end else begin
                  {acc_d, mq_d} = {mul_sum_s, mq_q[XLEN-1:1]};
               end
               if (cnt_q == CW'(XLEN-1)) begin
                  state_d = S_FIX;
               end else begin
                  state_d = S_RUN;
               end
            end
            S_FIX: begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               if (op_q[1]) begin
                  // A zero divisor naturally leaves |input1| as the remainder,
                  // so hi comes out as input1; only the quotient needs forcing.
                  hi_d = neg_x(rneg_q, acc_q);
                  if (mcand_q == '0) begin
                     lo_d = '1;
                     dz_d = 1'b1;
                  end else begin
                     lo_d = neg_x(qneg_q, mq_q);
                     dz_d = 1'b0;
                  end
               end else begin
                  {hi_d, lo_d} = prod_s;
                  dz_d = 1'b0;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= 2'b00;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         acc_q   <= '0;
         mq_q    <= '0;
         mcand_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         acc_q   <= acc_d;
         mq_q    <= mq_d;
         mcand_q <= mcand_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dz_q    <= dz_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- self-checking bench for muldiv_unit (XLEN = 32).
// Table of hand-computed vectors, a few random vectors against a reference
// model, and hand-written sequences for ignore/back-to-back/flush/reset.
module tb_muldiv_unit;

   logic clk;
   logic rst_n;
`ifdef MULDIV_FLUSH_EN
   logic flush;
`endif

   muldiv_unit_if #(.XLEN(32)) bus ();

   muldiv_unit #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef MULDIV_FLUSH_EN
      .flush (flush),
`endif
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   vec_t        vecs [12];
   exp_t        sb [$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] last_hi, last_lo;
   logic        last_dz;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Independent reference using native 64-bit / 32-bit arithmetic.
   function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [63:0] p;
      e.dz = 1'b0;
      e.hi = 32'h0;
      e.lo = 32'h0;
      case (op)
         2'b00: begin
            p = {32'h0, a} * {32'h0, b};
            e.hi = p[63:32];
            e.lo = p[31:0];
         end
         2'b01: begin
            p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            e.hi = p[63:32];
            e.lo = p[31:0];
         end
         2'b10: begin
            if (b == 32'h0) begin
               e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1;
            end else begin
               e.lo = a / b; e.hi = a % b;
            end
         end
         default: begin
            if (b == 32'h0) begin
               e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               e.lo = 32'h8000_0000; e.hi = 32'h0;
            end else begin
               e.lo = $signed(a) / $signed(b);
               e.hi = $signed(a) % $signed(b);
            end
         end
      endcase
      return e;
   endfunction

   // Called just after a negedge; start is sampled at the next posedge.
   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit push, input exp_t e);
      bus.start  = 1'b1;
      bus.op     = op;
      bus.input1 = a;
      bus.input2 = b;
      if (push) sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_after_start", {31'h0, bus.busy}, 32'd1);
      check("done_low_after_start", {31'h0, bus.done}, 32'd0);
   endtask

   // Waits for done (bounded), checks latency/busy and pops the scoreboard.
   // inject_at >= 0 pulses start with junk operands at that cycle of the run.
   task automatic wait_done(input string nm, input int inject_at);
      int   k;
      int   busy_cnt;
      exp_t e;
      k = 0;
      busy_cnt = 1;
      while (1) begin
         @(posedge clk);
         @(negedge clk);
         k++;
         if (bus.done) break;
         if (bus.busy) busy_cnt++;
         if (k == inject_at) begin
            bus.start = 1'b1; bus.op = 2'b10; bus.input1 = 32'h1; bus.input2 = 32'h0;
         end else if (k == inject_at + 1) begin
            bus.start = 1'b0; bus.input1 = 32'h5A5A_5A5A; bus.input2 = 32'h3;
         end
         if (k > 60) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no done after %0d cycles, expected done at 33", nm, k);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
         end
      end
      check({nm, "_latency"}, k, 32'd33);
      check({nm, "_busy_cycles"}, busy_cnt, 32'd33);
      check({nm, "_busy_with_done"}, {31'h0, bus.busy}, 32'd0);
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s_scoreboard: got done with empty queue, expected a pending result", nm);
      end else begin
         e = sb.pop_front();
         check({nm, "_hi"}, bus.hi, e.hi);
         check({nm, "_lo"}, bus.lo, e.lo);
         check({nm, "_dz"}, {31'h0, bus.div_by_zero}, {31'h0, e.dz});
         last_hi = e.hi; last_lo = e.lo; last_dz = e.dz;
      end
   endtask

   // Runs n cycles and checks that no done pulse appears.
   task automatic expect_quiet(input string nm, input int n);
      int dones = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      check({nm, "_no_done"}, dones, 32'd0);
      check({nm, "_idle"}, {31'h0, bus.busy}, 32'd0);
   endtask

   initial begin
      exp_t e;
      logic [1:0]  rop;
      logic [31:0] ra, rb;

      vecs[0]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
      vecs[1]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[3]  = '{2'b10, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
      vecs[4]  = '{2'b00, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b0};
      vecs[5]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
      vecs[6]  = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
      vecs[7]  = '{2'b10, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
      vecs[8]  = '{2'b11, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
      vecs[9]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
      vecs[10] = '{2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0};
      vecs[11] = '{2'b00, 32'h0000_0000, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 1'b0};

      rst_n = 1'b0;
      bus.start = 1'b0; bus.op = 2'b00; bus.input1 = 32'h0; bus.input2 = 32'h0;
`ifdef MULDIV_FLUSH_EN
      flush = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_busy", {31'h0, bus.busy}, 32'd0);
      check("rst_done", {31'h0, bus.done}, 32'd0);
      check("rst_hi", bus.hi, 32'h0);
      check("rst_lo", bus.lo, 32'h0);
      check("rst_dz", {31'h0, bus.div_by_zero}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven vectors.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         e.hi = vecs[i].hi; e.lo = vecs[i].lo; e.dz = vecs[i].dz;
         start_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, e);
         wait_done($sformatf("vec%0d", i), -1);
      end

      // Random vectors against the reference model.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         if (i % 2 == 1) rb = rb >> $urandom_range(4, 28);
         start_op(rop, ra, rb, 1'b1, model(rop, ra, rb));
         wait_done($sformatf("rnd%0d", i), -1);
      end

      // start + operand changes mid-run must be ignored.
      @(negedge clk);
      start_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 1'b1, model(2'b01, 32'hFFFF_FFFD, 32'h0000_0005));
      wait_done("ignore", 10);
      @(negedge clk);
      check("ignore_no_restart", {31'h0, bus.busy}, 32'd0);
      check("ignore_hold_lo", bus.lo, 32'hFFFF_FFF1);

      // Back-to-back: second start issued in the done cycle.
      @(negedge clk);
      start_op(2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1, model(2'b11, 32'h0000_0007, 32'hFFFF_FFFE));
      wait_done("b2b_first", -1);
      start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, model(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
      wait_done("b2b_second", -1);

`ifdef MULDIV_FLUSH_EN
      // Flush at cycle 15: back to idle, no done, results unchanged.
      @(negedge clk);
      start_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, e);
      repeat (14) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", {31'h0, bus.busy}, 32'd0);
      check("flush_done", {31'h0, bus.done}, 32'd0);
      check("flush_hi", bus.hi, last_hi);
      check("flush_lo", bus.lo, last_lo);
      check("flush_dz", {31'h0, bus.div_by_zero}, {31'h0, last_dz});
      expect_quiet("flush", 40);
`endif

      // Reset at cycle 15 of a multiply: outputs clear at once, no done after.
      @(negedge clk);
      start_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, e);
      repeat (14) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_busy", {31'h0, bus.busy}, 32'd0);
      check("arst_done", {31'h0, bus.done}, 32'd0);
      check("arst_hi", bus.hi, 32'h0);
      check("arst_lo", bus.lo, 32'h0);
      check("arst_dz", {31'h0, bus.div_by_zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      expect_quiet("arst", 40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
